// File: rtl/gomoku_win_scanner.sv
// Gomoku N-in-a-row detector: after a placement, walks the four lines
// through the new stone via a 1-cell synchronous read port.
module gomoku_win_scanner #(
    parameter int GRID_SIZE  = 15,
    parameter int WIN_LEN    = 5,
    parameter int COORD_W    = 4,
    parameter int EXACT_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic [1:0]         player,
    output logic               busy,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    input  logic [1:0]         rd_data,
    output logic               done,
    output logic               win,
    output logic [1:0]         win_dir,
    output logic [COORD_W:0]   run_len
);

    localparam int CW = COORD_W + 1;
    // One extra cell of look-ahead lets exact mode see an overline.
    localparam logic [CW-1:0] CAP =
        CW'(EXACT_MODE != 0 ? WIN_LEN + 1 : WIN_LEN);
    localparam logic [CW-1:0] WLEN = CW'(WIN_LEN);
    localparam logic [COORD_W-1:0] MAXC = COORD_W'(GRID_SIZE - 1);

    typedef enum logic [2:0] {IDLE, REQ, CHK, EVAL, DONE} state_t;

    state_t             state;
    logic [COORD_W-1:0] sx, sy, cx, cy;
    logic [1:0]         ply, dir;
    logic               side;
    logic [CW-1:0]      count, best;

    logic               x_inc, x_dec, y_inc, y_dec;
    logic               step_ok, hit;
    logic [COORD_W-1:0] nx, ny;
    logic [CW-1:0]      best_nxt;

    // Next cell along the current direction/side, with bounds and cap test.
    always_comb begin
        x_inc = (dir != 2'd1) && !side;
        x_dec = (dir != 2'd1) && side;
        y_inc = 1'b0;
        y_dec = 1'b0;
        case (dir)
            2'd1, 2'd2: begin
                y_inc = !side;
                y_dec = side;
            end
            2'd3: begin
                y_inc = side;
                y_dec = !side;
            end
            default: ;
        endcase
        nx = cx;
        if (x_inc) nx = cx + 1'b1;
        else if (x_dec) nx = cx - 1'b1;
        ny = cy;
        if (y_inc) ny = cy + 1'b1;
        else if (y_dec) ny = cy - 1'b1;
        step_ok = !(x_inc && cx >= MAXC) && !(x_dec && cx == '0)
               && !(y_inc && cy >= MAXC) && !(y_dec && cy == '0)
               && (nx <= MAXC) && (ny <= MAXC) && (count < CAP);
        hit = (EXACT_MODE != 0) ? (count == WLEN) : (count >= WLEN);
        best_nxt = (count > best) ? count : best;
    end

    // The read strobe belongs to the REQ cycle so data returns in CHK.
    assign rd_en = (state == REQ) && step_ok;
    assign rd_x  = rd_en ? nx : '0;
    assign rd_y  = rd_en ? ny : '0;

    // Scan FSM: per direction walk forward, then backward, then evaluate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            win     <= 1'b0;
            win_dir <= 2'd0;
            run_len <= '0;
            sx      <= '0;
            sy      <= '0;
            cx      <= '0;
            cy      <= '0;
            ply     <= 2'd0;
            dir     <= 2'd0;
            side    <= 1'b0;
            count   <= '0;
            best    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sx      <= start_x;
                        sy      <= start_y;
                        cx      <= start_x;
                        cy      <= start_y;
                        ply     <= player;
                        dir     <= 2'd0;
                        side    <= 1'b0;
                        count   <= CW'(1);
                        best    <= '0;
                        win     <= 1'b0;
                        win_dir <= 2'd0;
                        run_len <= '0;
                        if (player == 2'd0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (step_ok) begin
                        cx    <= nx;
                        cy    <= ny;
                        state <= CHK;
                    end else if (!side) begin
                        side <= 1'b1;
                        cx   <= sx;
                        cy   <= sy;
                    end else begin
                        state <= EVAL;
                    end
                end
                CHK: begin
                    if (rd_data == ply) begin
                        count <= count + 1'b1;
                        state <= REQ;
                    end else if (!side) begin
                        side  <= 1'b1;
                        cx    <= sx;
                        cy    <= sy;
                        state <= REQ;
                    end else begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (hit) begin
                        win     <= 1'b1;
                        win_dir <= dir;
                        run_len <= count;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (dir != 2'd3) begin
                        dir   <= dir + 1'b1;
                        side  <= 1'b0;
                        cx    <= sx;
                        cy    <= sy;
                        count <= CW'(1);
                        best  <= best_nxt;
                        state <= REQ;
                    end else begin
                        run_len <= best_nxt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gomoku_win_scanner.sv
// Bench for gomoku_win_scanner: normal and exact-mode instances share
// one board and are checked against a line-walking reference model.
module tb_gomoku_win_scanner;

    localparam int G  = 15;
    localparam int WL = 5;
    localparam int CWD = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [CWD-1:0] start_x, start_y;
    logic [1:0] player;

    logic busy_n, rd_en_n, done_n, win_n;
    logic [CWD-1:0] rd_x_n, rd_y_n;
    logic [1:0] rd_data_n, win_dir_n;
    logic [CWD:0] run_len_n;

    logic busy_e, rd_en_e, done_e, win_e;
    logic [CWD-1:0] rd_x_e, rd_y_e;
    logic [1:0] rd_data_e, win_dir_e;
    logic [CWD:0] run_len_e;

    int board[G][G];
    int total = 0;
    int bad = 0;
    int reads_n = 0, reads_e = 0;
    int dones_n = 0, dones_e = 0;
    int oob = 0;
    int dxs[4] = '{1, 0, 1, 1};
    int dys[4] = '{0, 1, 1, -1};

    always #5 clk = ~clk;

    gomoku_win_scanner #(
        .GRID_SIZE(G), .WIN_LEN(WL), .COORD_W(CWD), .EXACT_MODE(0)
    ) dut_n (
        .clk(clk), .rst(rst), .start(start),
        .start_x(start_x), .start_y(start_y), .player(player),
        .busy(busy_n), .rd_en(rd_en_n), .rd_x(rd_x_n), .rd_y(rd_y_n),
        .rd_data(rd_data_n), .done(done_n), .win(win_n),
        .win_dir(win_dir_n), .run_len(run_len_n)
    );

    gomoku_win_scanner #(
        .GRID_SIZE(G), .WIN_LEN(WL), .COORD_W(CWD), .EXACT_MODE(1)
    ) dut_e (
        .clk(clk), .rst(rst), .start(start),
        .start_x(start_x), .start_y(start_y), .player(player),
        .busy(busy_e), .rd_en(rd_en_e), .rd_x(rd_x_e), .rd_y(rd_y_e),
        .rd_data(rd_data_e), .done(done_e), .win(win_e),
        .win_dir(win_dir_e), .run_len(run_len_e)
    );

    // Board storage with a one-cycle read latency per instance.
    always @(posedge clk) begin
        if (rd_en_n && rd_x_n < G && rd_y_n < G)
            rd_data_n <= 2'(board[rd_x_n][rd_y_n]);
        if (rd_en_e && rd_x_e < G && rd_y_e < G)
            rd_data_e <= 2'(board[rd_x_e][rd_y_e]);
    end

    // Per-scan read and done counters, plus out-of-range read watch.
    always @(posedge clk) begin
        if (start && !busy_n && !done_n) begin
            reads_n <= 0;
            dones_n <= 0;
        end else begin
            reads_n <= reads_n + int'(rd_en_n);
            dones_n <= dones_n + int'(done_n);
        end
        if (start && !busy_e && !done_e) begin
            reads_e <= 0;
            dones_e <= 0;
        end else begin
            reads_e <= reads_e + int'(rd_en_e);
            dones_e <= dones_e + int'(done_e);
        end
        if ((rd_en_n && (rd_x_n >= G || rd_y_n >= G)) ||
            (rd_en_e && (rd_x_e >= G || rd_y_e >= G)))
            oob <= oob + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Walks each line outward from the stone as the rules describe.
    function automatic void model(input int x, input int y, input int p,
                                  input bit exact, output int mwin,
                                  output int mdir, output int mlen,
                                  output int mreads);
        int cap, best, cnt, cx, cy, nx, ny, s;
        cap = exact ? WL + 1 : WL;
        mwin = 0;
        mdir = 0;
        mlen = 0;
        mreads = 0;
        best = 0;
        if (p == 0) return;
        for (int d = 0; d < 4; d++) begin
            cnt = 1;
            for (int si = 0; si < 2; si++) begin
                s = (si == 0) ? 1 : -1;
                cx = x;
                cy = y;
                for (int k = 0; k < G; k++) begin
                    nx = cx + s * dxs[d];
                    ny = cy + s * dys[d];
                    if (nx < 0 || nx >= G || ny < 0 || ny >= G) break;
                    if (cnt >= cap) break;
                    mreads++;
                    if (board[nx][ny] != p) break;
                    cnt++;
                    cx = nx;
                    cy = ny;
                end
            end
            if (exact ? (cnt == WL) : (cnt >= WL)) begin
                mwin = 1;
                mdir = d;
                mlen = cnt;
                return;
            end
            if (cnt > best) best = cnt;
        end
        mlen = best;
    endfunction

    task automatic clear_board();
        for (int i = 0; i < G; i++)
            for (int j = 0; j < G; j++)
                board[i][j] = 0;
    endtask

    task automatic scan(input int x, input int y, input int p,
                        input bit mid);
        int w0, d0, l0, r0, w1, d1, l1, r1;
        int cyc, lat_n, lat_e, bnd_n, bnd_e;
        model(x, y, p, 1'b0, w0, d0, l0, r0);
        model(x, y, p, 1'b1, w1, d1, l1, r1);
        bnd_n = 4 * (2 * WL + 3) + 2;
        bnd_e = 4 * (2 * (WL + 1) + 3) + 2;
        lat_n = 999;
        lat_e = 999;
        @(negedge clk);
        start = 1'b1;
        start_x = CWD'(x);
        start_y = CWD'(y);
        player = 2'(p);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while ((lat_n == 999 || lat_e == 999) && cyc <= 200) begin
            if (done_n && lat_n == 999) lat_n = cyc;
            if (done_e && lat_e == 999) lat_e = cyc;
            if (mid && cyc == 3) begin
                start = 1'b1;
                start_x = CWD'($urandom_range(G - 1));
                start_y = CWD'($urandom_range(G - 1));
                player = 2'($urandom_range(1, 2));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("lat_n_bound", int'(lat_n <= bnd_n), 1);
        chk("lat_e_bound", int'(lat_e <= bnd_e), 1);
        if (p == 0) begin
            chk("lat_n_p0", lat_n, 1);
            chk("lat_e_p0", lat_e, 1);
        end
        chk("win_n", win_n, w0);
        chk("dir_n", win_dir_n, d0);
        chk("len_n", run_len_n, l0);
        chk("reads_n", reads_n, r0);
        chk("dones_n", dones_n, 1);
        chk("busy_n", busy_n, 0);
        chk("win_e", win_e, w1);
        chk("dir_e", win_dir_e, d1);
        chk("len_e", run_len_e, l1);
        chk("reads_e", reads_e, r1);
        chk("dones_e", dones_e, 1);
        chk("busy_e", busy_e, 0);
    endtask

    initial begin
        int x, y, p, d, len, off, px, py;
        bit mid;
        int waited;
        clear_board();
        rst = 1'b1;
        start = 1'b1;
        start_x = 4'd3;
        start_y = 4'd3;
        player = 2'd1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_n, 0);
        chk("rst_rd_en", rd_en_n, 0);
        chk("rst_done", done_n, 0);
        chk("rst_win", win_n, 0);
        chk("rst_dir", win_dir_n, 0);
        chk("rst_len", run_len_n, 0);
        chk("rst_rdx", rd_x_n, 0);
        chk("rst_rdy", rd_y_n, 0);
        chk("rst_busy_e", busy_e, 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_nobusy", busy_n, 0);
        chk("rst_nodone", done_n, 0);

        for (int i = 3; i <= 7; i++) board[i][7] = 1;
        scan(5, 7, 1, 1'b0);
        chk("t2_win", win_n, 1);
        chk("t2_dir", win_dir_n, 0);
        chk("t2_len", run_len_n, 5);
        chk("t2_reads", reads_n, 5);

        clear_board();
        for (int i = 0; i < 5; i++) board[i][14 - i] = 2;
        scan(4, 10, 2, 1'b0);
        chk("t3_win", win_n, 1);
        chk("t3_dir", win_dir_n, 3);

        clear_board();
        for (int i = 0; i <= 5; i++) board[2][i] = 1;
        scan(2, 5, 1, 1'b0);
        chk("t4_win_n", win_n, 1);
        chk("t4_dir_n", win_dir_n, 1);
        chk("t4_len_n", run_len_n, 5);
        chk("t4_win_e", win_e, 0);
        chk("t4_len_e", run_len_e, 6);

        clear_board();
        board[0][0] = 1;
        scan(0, 0, 1, 1'b1);
        chk("t5_win", win_n, 0);
        chk("t5_len", run_len_n, 1);
        scan(6, 6, 0, 1'b0);
        chk("t5_p0_reads", reads_n, 0);

        clear_board();
        for (int i = 3; i <= 7; i++) board[i][7] = 1;
        @(negedge clk);
        start = 1'b1;
        start_x = 4'd5;
        start_y = 4'd7;
        player = 2'd1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!rd_en_n && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("t6_saw_read", int'(rd_en_n), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_busy", busy_n, 0);
        chk("t6_done", done_n, 0);
        repeat (10) @(negedge clk);
        chk("t6_nodone", dones_n, 0);
        scan(5, 7, 1, 1'b0);
        chk("t6_win", win_n, 1);
        chk("t6_len", run_len_n, 5);

        for (int it = 0; it < 40; it++) begin
            clear_board();
            for (int i = 0; i < G; i++)
                for (int j = 0; j < G; j++)
                    if ($urandom_range(9) < 3)
                        board[i][j] = $urandom_range(1, 2);
            x = $urandom_range(G - 1);
            y = $urandom_range(G - 1);
            p = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 2);
            if (p != 0 && $urandom_range(1) == 1) begin
                d = $urandom_range(3);
                len = $urandom_range(2, 7);
                off = $urandom_range(len - 1);
                for (int k = 0; k < len; k++) begin
                    px = x + (k - off) * dxs[d];
                    py = y + (k - off) * dys[d];
                    if (px >= 0 && px < G && py >= 0 && py < G)
                        board[px][py] = p;
                end
            end
            if (p != 0) board[x][y] = p;
            mid = (p != 0) && ($urandom_range(1) == 1);
            scan(x, y, p, mid);
        end

        chk("oob_reads", oob, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
